// File: rtl/bcp_pe_walker.sv
// BCP processing element: walks one literal's clause list, emits implications or a conflict.
// Optional saturating statistics counters are enabled with `define BCP_PE_STATS_EN.
module bcp_pe_walker #(
    parameter int LIT_W   = 8,
    parameter int CLA_LEN = 3,
    parameter int PTR_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       lit_in_valid,
    output logic                       lit_in_ready,
    input  logic [LIT_W-1:0]           lit_in,
    input  logic [PTR_W-1:0]           head_ptr,
    input  logic                       head_valid,
    output logic                       node_req_valid,
    output logic [PTR_W-1:0]           node_req_ptr,
    input  logic                       node_rsp_valid,
    input  logic [CLA_LEN*LIT_W-1:0]   node_rsp_lit,
    input  logic [CLA_LEN*PTR_W-1:0]   node_rsp_next,
    output logic [CLA_LEN*(LIT_W-1)-1:0] var_idx,
    input  logic [CLA_LEN*2-1:0]       var_state,
    output logic                       imply_valid,
    input  logic                       imply_ready,
    output logic [LIT_W-1:0]           imply_lit,
    output logic                       conflict_valid,
    output logic [PTR_W-1:0]           conflict_ptr,
    input  logic                       halt,
`ifdef BCP_PE_STATS_EN
    input  logic                       stat_clr,
    output logic [31:0]                stat_clauses,
    output logic [31:0]                stat_implies,
    output logic [31:0]                stat_conflicts,
`endif
    output logic                       busy
);

    // state | meaning
    // IDLE  | waiting for a literal from the arbiter
    // REQ   | issuing a node read for ptr_q
    // WAIT  | waiting for the node memory response
    // EVAL  | classifying the clause slots against var_state
    // EMIT  | presenting an implication until accepted
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EVAL, S_EMIT} state_t;

    localparam int VW = LIT_W - 1;

    state_t state_q, state_d;

    logic [LIT_W-1:0]         lit_q;
    logic [PTR_W-1:0]         ptr_q;
    logic [PTR_W-1:0]         next_q;
    logic [CLA_LEN*LIT_W-1:0] node_lit_q;
    logic [CLA_LEN*PTR_W-1:0] node_next_q;
    logic [LIT_W-1:0]         imply_lit_q;
    logic                     imply_done_q;
    logic                     conflict_valid_q;
    logic [PTR_W-1:0]         conflict_ptr_q;

    logic [LIT_W-1:0] slot_lit;
    logic [LIT_W-1:0] slot_abs;
    logic [1:0]       slot_st;
    logic             any_true;
    logic [7:0]       undef_cnt;
    logic [LIT_W-1:0] undef_lit;
    logic [PTR_W-1:0] next_sel;
    logic             match_found;
    logic             eval_advance;
    logic             eval_conflict;
    logic             accept;

    // Clause classification straight off the node register
    always_comb begin
        var_idx     = '0;
        any_true    = 1'b0;
        undef_cnt   = 8'd0;
        undef_lit   = '0;
        next_sel    = '0;
        match_found = 1'b0;
        slot_lit    = '0;
        slot_abs    = '0;
        slot_st     = 2'b00;
        for (int i = 0; i < CLA_LEN; i++) begin
            slot_lit = node_lit_q[i*LIT_W +: LIT_W];
            slot_st  = var_state[i*2 +: 2];
            slot_abs = slot_lit[LIT_W-1] ? -slot_lit : slot_lit;
            if (slot_lit != '0) begin
                var_idx[i*VW +: VW] = slot_abs[VW-1:0];
                if ((!slot_lit[LIT_W-1] && slot_st == 2'b10) ||
                    ( slot_lit[LIT_W-1] && slot_st == 2'b01))
                    any_true = 1'b1;
                if (slot_st == 2'b00) begin
                    undef_cnt = undef_cnt + 8'd1;
                    undef_lit = slot_lit;
                end
            end
            if (!match_found && slot_lit == lit_q) begin
                match_found = 1'b1;
                next_sel    = node_next_q[i*PTR_W +: PTR_W];
            end
        end
    end

    assign eval_advance  = any_true || (undef_cnt >= 8'd2);
    assign eval_conflict = !eval_advance && (undef_cnt == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        lit_in_ready   = 1'b0;
        node_req_valid = 1'b0;
        imply_valid    = 1'b0;
        case (state_q)
            S_IDLE: begin
                lit_in_ready = !halt && rst_n;
                if (lit_in_valid && !halt && head_valid && head_ptr != '0)
                    state_d = S_REQ;
            end
            S_REQ: begin
                if (!halt) begin
                    node_req_valid = 1'b1;
                    state_d        = S_WAIT;
                end
            end
            S_WAIT: begin
                if (node_rsp_valid) state_d = S_EVAL;
            end
            S_EVAL: begin
                if (!halt) begin
                    if (eval_advance)       state_d = (next_sel != '0) ? S_REQ : S_IDLE;
                    else if (eval_conflict) state_d = S_IDLE;
                    else                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                // Once accepted under halt, valid drops but the state waits for halt release
                imply_valid = !imply_done_q;
                if (!halt && (imply_done_q || imply_ready))
                    state_d = (next_q != '0) ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign accept = lit_in_valid && lit_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lit_q            <= '0;
            ptr_q            <= '0;
            next_q           <= '0;
            node_lit_q       <= '0;
            node_next_q      <= '0;
            imply_lit_q      <= '0;
            imply_done_q     <= 1'b0;
            conflict_valid_q <= 1'b0;
            conflict_ptr_q   <= '0;
        end else begin
            conflict_valid_q <= 1'b0;
            conflict_ptr_q   <= '0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        lit_q <= lit_in;
                        if (head_valid && head_ptr != '0) ptr_q <= head_ptr;
                    end
                end
                S_WAIT: begin
                    if (node_rsp_valid) begin
                        node_lit_q  <= node_rsp_lit;
                        node_next_q <= node_rsp_next;
                    end
                end
                S_EVAL: begin
                    if (!halt) begin
                        next_q       <= next_sel;
                        imply_done_q <= 1'b0;
                        if (eval_advance) begin
                            if (next_sel != '0) ptr_q <= next_sel;
                        end else if (eval_conflict) begin
                            conflict_valid_q <= 1'b1;
                            conflict_ptr_q   <= ptr_q;
                        end else begin
                            imply_lit_q <= undef_lit;
                        end
                    end
                end
                S_EMIT: begin
                    if (imply_valid && imply_ready) imply_done_q <= 1'b1;
                    if (state_d != S_EMIT && next_q != '0) ptr_q <= next_q;
                end
                default: ;
            endcase
        end
    end

    assign node_req_ptr   = node_req_valid ? ptr_q : '0;
    assign imply_lit      = imply_valid ? imply_lit_q : '0;
    assign conflict_valid = conflict_valid_q;
    assign conflict_ptr   = conflict_ptr_q;
    assign busy           = (state_q != S_IDLE);

`ifdef BCP_PE_STATS_EN
    logic [31:0] clauses_q, implies_q, conflicts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clauses_q   <= '0;
            implies_q   <= '0;
            conflicts_q <= '0;
        end else if (stat_clr) begin
            clauses_q   <= '0;
            implies_q   <= '0;
            conflicts_q <= '0;
        end else begin
            if (state_q == S_EVAL && !halt && clauses_q != '1) clauses_q <= clauses_q + 32'd1;
            if (imply_valid && imply_ready && implies_q != '1) implies_q <= implies_q + 32'd1;
            if (conflict_valid_q && conflicts_q != '1)         conflicts_q <= conflicts_q + 32'd1;
        end
    end

    assign stat_clauses   = clauses_q;
    assign stat_implies   = implies_q;
    assign stat_conflicts = conflicts_q;
`endif

endmodule

// File: doc/bcp_pe_walker.md
# bcp_pe_walker

Parametrised BCP processing element. It accepts a newly assigned literal from the unit-clause arbiter and walks that literal's clause linked list through a registered node-memory port. For each clause it looks up variable states in the global state table, then emits at most one implication per clause through a valid/ready handshake, or a conflict pulse. It sits between the UCQ arbiter, the clause-list head table, the clause node memory and the global state table. It generalises the earlier BCP PE in clause length, literal width and pointer width, and adds memory latency tolerance, implication backpressure and early abort on conflict.

## Interface
- LIT_W, 8, literal width; signed two's complement; 0 = empty slot
- CLA_LEN, 3, literal slots per clause node
- PTR_W, 8, node pointer width; 0 = null/end of list
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lit_in_valid / lit_in_ready  in/out  1  new-literal handshake
- lit_in  in  LIT_W  literal being propagated
- head_ptr / head_valid  in  PTR_W/1  list head for lit_in (combinational, same cycle)
- node_req_valid  out  1  node read request
- node_req_ptr  out  PTR_W  address of the node to read
- node_rsp_valid  in  1  read data valid (latency ≥1)
- node_rsp_lit  in  CLA_LEN*LIT_W  clause literals, slot i at [i*LIT_W +: LIT_W]
- node_rsp_next  in  CLA_LEN*PTR_W  per-slot next pointers
- var_idx  out  CLA_LEN*(LIT_W-1)  |literal| per slot (0 for empty slot)
- var_state  in  CLA_LEN*2  per slot: 00 UNDEF, 01 FALSE, 10 TRUE (same cycle)
- imply_valid / imply_ready  out/in  1  implication handshake
- imply_lit  out  LIT_W  implied literal
- conflict_valid  out  1  one-cycle conflict pulse
- conflict_ptr  out  PTR_W  conflicting node address
- halt  in  1  freeze from clause arbiter
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, WAIT, EVAL, EMIT.
- **IDLE.** lit_in_ready = !halt. When a literal is accepted, it is latched.
  - If head_valid and head_ptr != 0: go to REQ with ptr = head_ptr.
  - Otherwise: stay in IDLE. The literal is consumed.
- **REQ.** node_req_valid=1 and node_req_ptr=ptr for exactly one cycle, then go to WAIT.
- **WAIT.** On node_rsp_valid, capture the literals and next pointers into the node register, then go to EVAL. Capture happens even while halt is asserted.
- **EVAL.** var_idx is driven from the node register.
  - Slot i is true if its literal is nonzero and either (literal > 0 and TRUE) or (literal < 0 and FALSE).
  - Slot i is undef if its literal is nonzero and its state is UNDEF. Empty slots are ignored.
  - next = the next pointer of the lowest slot whose literal equals the latched literal. If no slot matches, next = 0.
  - Any slot true: go to REQ if next != 0, else IDLE.
  - No slot true and no slot undef: pulse conflict_valid with conflict_ptr=ptr, then go to IDLE. The rest of the list is discarded.
  - No slot true and exactly one slot undef: go to EMIT with imply_lit = that slot's literal.
  - Two or more slots undef: advance as in the "any slot true" case.
- **EMIT.** imply_valid=1 and imply_lit stays stable until imply_ready. On the handshake, go to REQ if next != 0, else IDLE.
- **halt.** Blocks the IDLE accept, the REQ issue and EVAL resolution. In EVAL, no conflict or implication is produced and the state is held; evaluation is redone with fresh var_state after halt drops. In EMIT, imply_valid is not retracted; the handshake may complete, but the state stays in EMIT until halt drops.

## Timing
- Reset (asynchronous): state IDLE and every register cleared. All outputs are 0, including lit_in_ready while rst_n=0.
- Literal accept to node_req_valid: 1 cycle.
- Per clause: REQ 1 cycle + WAIT (memory latency) + EVAL 1 cycle. That is 3 cycles per clause at 1-cycle memory latency, plus EMIT cycles for implications.
- conflict_valid is registered and asserts the cycle after EVAL resolves.
- imply_valid asserts the first cycle of EMIT.
- Asserting rst_n mid-walk aborts the walk; no node_req is issued after reset.
- node_rsp_valid outside WAIT is ignored.

## Configuration
- BCP_PE_STATS_EN defined: adds the following ports.
  - stat_clr  in  1
  - stat_clauses, stat_implies, stat_conflicts  out  32 each
  - Counters saturate. They increment on EVAL resolution, on the imply handshake and on the conflict pulse respectively. They are cleared by reset or stat_clr; stat_clr wins over a simultaneous increment.
- BCP_PE_STATS_EN undefined: these ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset: hold rst_n=0 with lit_in_valid=1 → lit_in_ready=0 and all outputs 0. First cycle after release with halt=0 → lit_in_ready=1.
- Implication:
  - Stimulus: lit_in=5, head_ptr=4. node4 = {5,-2,7}, next = {0,0,0}. States: var5 FALSE, var2 TRUE, var7 UNDEF. imply_ready held low for 3 cycles.
  - Response: imply_lit=7 held stable with imply_valid=1 for 4 cycles, then IDLE with busy=0.
- Conflict: same as the implication case but var7 FALSE → conflict_valid=1 for 1 cycle with conflict_ptr=4; no further node_req; back to IDLE.
- List walk:
  - Stimulus: head 4. node4 = {5,3,0}, next slot0 = 9. node9 = {-3,5,0}, next slot1 = 0. var3 TRUE, 2-cycle memory latency.
  - Response: node_req_ptr sequence is exactly 4 then 9; no implication or conflict; IDLE afterwards.
- Halt: raise halt during EVAL of a conflicting clause → no conflict pulse while halted. Drop halt with var7 now UNDEF → imply_lit=7.
- Empty list and reset:
  - head_valid=0 → literal consumed with zero node_req.
  - rst_n low in WAIT → IDLE immediately; a later node_rsp_valid is ignored.
  - With BCP_PE_STATS_EN: stat_clauses increments once per clause evaluated.
